r_ctrl_sync: RTL and testbench
==============================

// Module: r_ctrl_sync
// PURPOSE
//  Read-side pointer/flag controller of the dual-clock FIFO; pairs with the write controller.
//  Runs in the read clock domain and advances a binary read pointer on accepted reads.
//  Drives the dual-port RAM read address and exports the Gray read pointer to the write side.
//  Synchronises the write-side Gray pointer (2 flops) and derives empty, almost-empty, level and underflow.
// PARAMETERS
//  ADDR_W      3   RAM address width; depth = 2**ADDR_W; pointers are ADDR_W+1 bits
//  AEMPTY_TH   1   r_aempty asserted when level <= AEMPTY_TH
// PORTS
//  r_clk        in   1         read clock
//  rst          in   1         synchronous reset, active-high
//  r_en         in   1         read request
//  w_gaddr      in   ADDR_W+1  write-side Gray pointer, write clock domain
//  r_ren        out  1         RAM read enable (accepted read)
//  r_addr       out  ADDR_W    RAM read address
//  r_gaddr      out  ADDR_W+1  registered Gray read pointer, to write side
//  r_valid      out  1         RAM read data valid
//  r_empty      out  1         FIFO empty
//  r_aempty     out  1         FIFO almost empty
//  r_level      out  ADDR_W+1  words available, conservative
//  r_underflow  out  1         one-cycle pulse on read attempt while empty
// BEHAVIOUR
//  - All state updates on posedge r_clk. rst=1 at an edge loads reset values.
//  - Reset values: r_empty=1, r_aempty=1, r_addr=0, r_gaddr=0, r_valid=0, r_level=0, r_underflow=0.
//    Both synchroniser flops also reset to 0.
//  - Reset mid-operation: any in-flight read is discarded; all state returns to reset values.
//    The write side is reset in the same event.
//  - Synchroniser: w_g_d1 <= w_gaddr; w_g_d2 <= w_g_d1. Only w_g_d2 feeds any logic.
//  - Read acceptance: rd_fire = r_en & ~r_empty (combinational).
//    r_ren = rd_fire. A read request while empty is ignored.
//  - Pointer arithmetic:
//    - bin_nxt = bin + rd_fire, modulo 2**(ADDR_W+1).
//    - gray_nxt = (bin_nxt>>1) ^ bin_nxt.
//    - bin and r_gaddr are registered from bin_nxt and gray_nxt.
//  - r_addr = bin[ADDR_W-1:0]. The RAM samples r_addr when r_ren=1.
//    Data is valid one cycle later; r_valid <= rd_fire (1-cycle latency).
//  - Empty: r_empty <= (gray_nxt == w_g_d2). Uses next-state pointer, so no extra read can slip through.
//  - Level:
//    - w_bin = gray-to-binary(w_g_d2), where w_bin[i] = ^w_g_d2[ADDR_W:i].
//    - r_level <= (w_bin - bin_nxt) mod 2**(ADDR_W+1).
//    - Range is 0..2**ADDR_W. r_empty == (r_level==0) always holds.
//  - Almost empty: r_aempty <= (level_nxt <= AEMPTY_TH).
//  - Underflow: r_underflow <= r_en & r_empty. It is a pulse, not sticky.
//  - Write-to-empty latency: a write pointer change is visible on r_empty 3 r_clk edges after it is stable at w_gaddr.
//    Flags are pessimistic: empty may be held late, never released early.
//  - Wrap-around: bin rolls from 2**(ADDR_W+1)-1 to 0. r_addr rolls from 2**ADDR_W-1 to 0.
//    Pointer MSB distinguishes laps; no special-case logic is needed.
//  - Simultaneous read and w_gaddr change: the read uses the current r_empty.
//    The new write pointer is accounted for on later edges.
//  - Full-depth case (r_level = 2**ADDR_W) is legal and must not alias to empty.
// TESTING
//  1. Reset: rst=1 for 2 cycles, w_gaddr=0.
//     -> r_empty=1, r_aempty=1, r_addr=0, r_gaddr=0, r_valid=0, r_level=0, r_ren=0.
//  2. Single word: drive w_gaddr=4'b0001 (ADDR_W=3).
//     -> r_empty falls on the 3rd edge, r_level=1.
//     Then r_en=1 for 1 cycle -> r_ren=1 with r_addr=0.
//     Next edge: r_valid=1, r_empty=1, r_gaddr=4'b0001, r_level=0.
//  3. Underflow: r_en=1 while r_empty=1.
//     -> r_ren=0, r_underflow=1 for one cycle, r_addr and r_gaddr unchanged.
//  4. Full depth: w_gaddr=4'b1100 (gray 8) -> r_level=8, r_aempty=0.
//     8 back-to-back reads -> r_addr 0..7, r_level 7..0.
//     r_aempty asserts at level 1; r_empty=1 after the 8th read; r_gaddr=4'b1100.
//  5. Wrap-around: stream 20 words with w_gaddr stepping through Gray codes.
//     -> r_gaddr passes 4'b1000 -> 4'b0000 (bin 15->0), r_addr passes 7->0.
//     No spurious r_empty while r_level>0; data order is preserved.
//  6. Mid-stream reset: rst=1 with r_level=5 and r_en=1.
//     -> next edge gives all reset values; r_valid=0 and no r_ren during rst.

Source files
------------

// File: rtl/r_ctrl_sync_if.sv
// Read-side FIFO controller bus: request and write pointer in, RAM control and flags out.
interface r_ctrl_sync_if #(
  parameter int unsigned ADDR_W = 3
);
  logic              r_en;
  logic [ADDR_W:0]   w_gaddr;
  logic              r_ren;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_gaddr;
  logic              r_valid;
  logic              r_empty;
  logic              r_aempty;
  logic [ADDR_W:0]   r_level;
  logic              r_underflow;

  modport master (
    output r_en, w_gaddr,
    input  r_ren, r_addr, r_gaddr, r_valid, r_empty, r_aempty, r_level, r_underflow
  );

  modport slave (
    input  r_en, w_gaddr,
    output r_ren, r_addr, r_gaddr, r_valid, r_empty, r_aempty, r_level, r_underflow
  );
endinterface

// File: rtl/r_ctrl_sync.sv
// Read-side pointer/flag controller of a dual-clock FIFO.
// Keeps a binary read pointer, exports its Gray form to the write side,
// synchronises the write Gray pointer over two flops and derives the flags.
module r_ctrl_sync #(
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned AEMPTY_TH = 1
) (
  input  logic          r_clk,
  input  logic          rst,
  r_ctrl_sync_if.slave  bus
);
  localparam int unsigned PW = ADDR_W + 1;

  logic [ADDR_W:0] w_g_d1;
  logic [ADDR_W:0] w_g_d2;
  logic [ADDR_W:0] bin;
  logic [ADDR_W:0] bin_nxt;
  logic [ADDR_W:0] gray_nxt;
  logic [ADDR_W:0] w_bin;
  logic [ADDR_W:0] level_nxt;
  logic [ADDR_W:0] gaddr_q;
  logic [ADDR_W:0] level_q;
  logic            empty_q;
  logic            aempty_q;
  logic            valid_q;
  logic            underflow_q;
  logic            rd_fire;

  // Two-flop synchroniser for the write-domain Gray pointer
  always_ff @(posedge r_clk) begin
    if (rst) begin
      w_g_d1 <= '0;
      w_g_d2 <= '0;
    end else begin
      w_g_d1 <= bus.w_gaddr;
      w_g_d2 <= w_g_d1;
    end
  end

  // Read acceptance, next pointers and next level from the synchronised write pointer
  always_comb begin
    // Reset suppresses acceptance so no RAM read is issued while rst is held
    rd_fire  = bus.r_en & ~empty_q & ~rst;
    bin_nxt  = bin + PW'(rd_fire);
    gray_nxt = (bin_nxt >> 1) ^ bin_nxt;
    w_bin    = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      w_bin[i] = ^(w_g_d2 >> i);
    end
    level_nxt = w_bin - bin_nxt;
  end

  // Pointer, flag and level registers
  always_ff @(posedge r_clk) begin
    if (rst) begin
      bin         <= '0;
      gaddr_q     <= '0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
      level_q     <= '0;
      valid_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      bin         <= bin_nxt;
      gaddr_q     <= gray_nxt;
      empty_q     <= (gray_nxt == w_g_d2);
      aempty_q    <= (level_nxt <= PW'(AEMPTY_TH));
      level_q     <= level_nxt;
      valid_q     <= rd_fire;
      underflow_q <= bus.r_en & empty_q;
    end
  end

  assign bus.r_ren       = rd_fire;
  assign bus.r_addr      = bin[ADDR_W-1:0];
  assign bus.r_gaddr     = gaddr_q;
  assign bus.r_valid     = valid_q;
  assign bus.r_empty     = empty_q;
  assign bus.r_aempty    = aempty_q;
  assign bus.r_level     = level_q;
  assign bus.r_underflow = underflow_q;
endmodule

// File: tb/tb_r_ctrl_sync.sv
// Directed bench for the read-side FIFO controller (ADDR_W=3, AEMPTY_TH=1).
module tb_r_ctrl_sync;
  logic r_clk = 1'b0;
  logic rst   = 1'b1;
  int   checks = 0;
  int   passed = 0;

  r_ctrl_sync_if #(.ADDR_W(3)) bus ();

  r_ctrl_sync #(.ADDR_W(3), .AEMPTY_TH(1)) dut (
    .r_clk (r_clk),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 r_clk = ~r_clk;

  function automatic logic [3:0] gray4(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.r_en = 1'b0; bus.w_gaddr = 4'b0000;
    tick(); tick();
    checks++; if (bus.r_empty !== 1'b1) $display("FAIL rst_empty got %0h want 1", bus.r_empty); else passed++;
    checks++; if (bus.r_aempty !== 1'b1) $display("FAIL rst_aempty got %0h want 1", bus.r_aempty); else passed++;
    checks++; if (bus.r_addr !== 3'd0) $display("FAIL rst_addr got %0h want 0", bus.r_addr); else passed++;
    checks++; if (bus.r_gaddr !== 4'd0) $display("FAIL rst_gaddr got %0h want 0", bus.r_gaddr); else passed++;
    checks++; if (bus.r_valid !== 1'b0) $display("FAIL rst_valid got %0h want 0", bus.r_valid); else passed++;
    checks++; if (bus.r_level !== 4'd0) $display("FAIL rst_level got %0h want 0", bus.r_level); else passed++;
    checks++; if (bus.r_ren !== 1'b0) $display("FAIL rst_ren got %0h want 0", bus.r_ren); else passed++;
    checks++; if (bus.r_underflow !== 1'b0) $display("FAIL rst_uflow got %0h want 0", bus.r_underflow); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    bus.w_gaddr = 4'b0001;
    tick(); tick();
    checks++; if (bus.r_empty !== 1'b1) $display("FAIL sw_empty_edge2 got %0h want 1", bus.r_empty); else passed++;
    tick();
    checks++; if (bus.r_empty !== 1'b0) $display("FAIL sw_empty_edge3 got %0h want 0", bus.r_empty); else passed++;
    checks++; if (bus.r_level !== 4'd1) $display("FAIL sw_level got %0h want 1", bus.r_level); else passed++;
    checks++; if (bus.r_aempty !== 1'b1) $display("FAIL sw_aempty got %0h want 1", bus.r_aempty); else passed++;
    bus.r_en = 1'b1;
    #1;
    checks++; if (bus.r_ren !== 1'b1) $display("FAIL sw_ren got %0h want 1", bus.r_ren); else passed++;
    checks++; if (bus.r_addr !== 3'd0) $display("FAIL sw_addr got %0h want 0", bus.r_addr); else passed++;
    tick();
    bus.r_en = 1'b0;
    checks++; if (bus.r_valid !== 1'b1) $display("FAIL sw_valid got %0h want 1", bus.r_valid); else passed++;
    checks++; if (bus.r_empty !== 1'b1) $display("FAIL sw_empty_after got %0h want 1", bus.r_empty); else passed++;
    checks++; if (bus.r_gaddr !== 4'b0001) $display("FAIL sw_gaddr got %0h want 1", bus.r_gaddr); else passed++;
    checks++; if (bus.r_level !== 4'd0) $display("FAIL sw_level_after got %0h want 0", bus.r_level); else passed++;
    checks++; if (bus.r_underflow !== 1'b0) $display("FAIL sw_uflow got %0h want 0", bus.r_underflow); else passed++;
  endtask

  task automatic test_underflow();
    bus.r_en = 1'b1;
    #1;
    checks++; if (bus.r_ren !== 1'b0) $display("FAIL uf_ren got %0h want 0", bus.r_ren); else passed++;
    tick();
    bus.r_en = 1'b0;
    checks++; if (bus.r_underflow !== 1'b1) $display("FAIL uf_pulse got %0h want 1", bus.r_underflow); else passed++;
    checks++; if (bus.r_addr !== 3'd1) $display("FAIL uf_addr got %0h want 1", bus.r_addr); else passed++;
    checks++; if (bus.r_gaddr !== 4'b0001) $display("FAIL uf_gaddr got %0h want 1", bus.r_gaddr); else passed++;
    checks++; if (bus.r_valid !== 1'b0) $display("FAIL uf_valid got %0h want 0", bus.r_valid); else passed++;
    tick();
    checks++; if (bus.r_underflow !== 1'b0) $display("FAIL uf_clear got %0h want 0", bus.r_underflow); else passed++;
  endtask

  task automatic test_full_depth();
    test_reset();
    bus.w_gaddr = 4'b1100;
    tick(); tick(); tick();
    checks++; if (bus.r_level !== 4'd8) $display("FAIL fd_level got %0h want 8", bus.r_level); else passed++;
    checks++; if (bus.r_empty !== 1'b0) $display("FAIL fd_empty got %0h want 0", bus.r_empty); else passed++;
    checks++; if (bus.r_aempty !== 1'b0) $display("FAIL fd_aempty got %0h want 0", bus.r_aempty); else passed++;
    bus.r_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (bus.r_ren !== 1'b1) $display("FAIL fd_ren[%0d] got %0h want 1", k, bus.r_ren); else passed++;
      checks++; if (bus.r_addr !== 3'(k)) $display("FAIL fd_addr[%0d] got %0h want %0h", k, bus.r_addr, k); else passed++;
      tick();
      checks++; if (bus.r_level !== 4'(7 - k)) $display("FAIL fd_lvl[%0d] got %0h want %0h", k, bus.r_level, 7 - k); else passed++;
      checks++; if (bus.r_aempty !== ((7 - k) <= 1)) $display("FAIL fd_ae[%0d] got %0h want %0h", k, bus.r_aempty, (7 - k) <= 1); else passed++;
      checks++; if (bus.r_empty !== (k == 7)) $display("FAIL fd_em[%0d] got %0h want %0h", k, bus.r_empty, k == 7); else passed++;
    end
    checks++; if (bus.r_gaddr !== 4'b1100) $display("FAIL fd_gaddr got %0h want c", bus.r_gaddr); else passed++;
    #1;
    checks++; if (bus.r_ren !== 1'b0) $display("FAIL fd_ren_empty got %0h want 0", bus.r_ren); else passed++;
    bus.r_en = 1'b0;
  endtask

  // Writer advances one word per cycle (never more than 8 ahead); reader always requests.
  task automatic test_wrap();
    int  rb = 8;
    int  wb = 8;
    int  cyc = 0;
    bit  saw_g8 = 1'b0, saw_gwrap = 1'b0, saw_awrap = 1'b0;
    logic [2:0] last_addr = 3'd7;
    bus.r_en = 1'b1;
    while (rb < 28 && cyc < 300) begin
      cyc++;
      #1;
      if (bus.r_ren === 1'b1) begin
        checks++; if (bus.r_addr !== 3'(rb)) $display("FAIL wr_addr got %0h want %0h", bus.r_addr, 3'(rb)); else passed++;
        if (last_addr == 3'd7 && bus.r_addr == 3'd0 && rb > 8) saw_awrap = 1'b1;
        last_addr = bus.r_addr;
        rb++;
      end
      if (wb < 28 && (wb - rb) < 8) wb++;
      bus.w_gaddr = gray4(wb);
      tick();
      checks++; if (bus.r_gaddr !== gray4(rb)) $display("FAIL wr_gaddr got %0h want %0h", bus.r_gaddr, gray4(rb)); else passed++;
      checks++; if (bus.r_empty !== (bus.r_level == 4'd0)) $display("FAIL wr_empty_lvl got %0h want %0h", bus.r_empty, bus.r_level == 4'd0); else passed++;
      checks++; if (int'(bus.r_level) > (wb - rb)) $display("FAIL wr_level got %0d want <=%0d", bus.r_level, wb - rb); else passed++;
      if (bus.r_gaddr == 4'b1000) saw_g8 = 1'b1;
      if (saw_g8 && bus.r_gaddr == 4'b0000) saw_gwrap = 1'b1;
    end
    bus.r_en = 1'b0;
    checks++; if (rb !== 28) $display("FAIL wr_count got %0d want 28", rb); else passed++;
    checks++; if (saw_gwrap !== 1'b1) $display("FAIL wr_gray_wrap got %0h want 1", saw_gwrap); else passed++;
    checks++; if (saw_awrap !== 1'b1) $display("FAIL wr_addr_wrap got %0h want 1", saw_awrap); else passed++;
  endtask

  task automatic test_mid_reset();
    test_reset();
    bus.w_gaddr = 4'b0111;
    tick(); tick(); tick();
    checks++; if (bus.r_level !== 4'd5) $display("FAIL mr_level_pre got %0h want 5", bus.r_level); else passed++;
    bus.r_en = 1'b1;
    tick();
    rst = 1'b1; bus.w_gaddr = 4'b0000;
    #1;
    checks++; if (bus.r_ren !== 1'b0) $display("FAIL mr_ren_rst got %0h want 0", bus.r_ren); else passed++;
    tick();
    checks++; if (bus.r_empty !== 1'b1) $display("FAIL mr_empty got %0h want 1", bus.r_empty); else passed++;
    checks++; if (bus.r_aempty !== 1'b1) $display("FAIL mr_aempty got %0h want 1", bus.r_aempty); else passed++;
    checks++; if (bus.r_addr !== 3'd0) $display("FAIL mr_addr got %0h want 0", bus.r_addr); else passed++;
    checks++; if (bus.r_gaddr !== 4'd0) $display("FAIL mr_gaddr got %0h want 0", bus.r_gaddr); else passed++;
    checks++; if (bus.r_valid !== 1'b0) $display("FAIL mr_valid got %0h want 0", bus.r_valid); else passed++;
    checks++; if (bus.r_level !== 4'd0) $display("FAIL mr_level got %0h want 0", bus.r_level); else passed++;
    checks++; if (bus.r_underflow !== 1'b0) $display("FAIL mr_uflow got %0h want 0", bus.r_underflow); else passed++;
    checks++; if (bus.r_ren !== 1'b0) $display("FAIL mr_ren_hold got %0h want 0", bus.r_ren); else passed++;
    tick();
    checks++; if (bus.r_valid !== 1'b0) $display("FAIL mr_valid2 got %0h want 0", bus.r_valid); else passed++;
    rst = 1'b0; bus.r_en = 1'b0;
    tick();
  endtask

  initial begin
    bus.r_en = 1'b0;
    bus.w_gaddr = 4'b0000;
    test_reset();
    test_single_word();
    test_underflow();
    test_full_depth();
    test_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
